// File: rtl/tone_synth_pkg.sv
// Shared constants for the tone synthesiser: binary-angle CORDIC arctangent table,
// gain compensation, fixed-point guard bits and the control FSM encoding.
package tone_synth_pkg;

    localparam int ANGLE_WIDTH       = 32;
    localparam int CORDIC_INV_GAIN   = 19898;
    localparam int CORDIC_MAX_STAGES = 24;
    // Fractional bits carried through the rotator so the output can be rounded.
    localparam int FRAC_BITS         = 2;

    // atan(2^-i) expressed as a 32-bit binary angle (2^32 = one full turn).
    localparam logic [ANGLE_WIDTH-1:0] ATAN_TABLE [CORDIC_MAX_STAGES] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/tone_synth_if.sv
// Tone record sink and complex sample source of the tone synthesiser.
interface tone_synth_if
    import tone_synth_pkg::*;
#(
    parameter int DATA_WIDTH = 14
);
    logic                          sink_valid;
    logic                          sink_ready;
    logic signed [ANGLE_WIDTH-1:0] sink_freq;
    logic signed [ANGLE_WIDTH-1:0] sink_phase;
    logic signed [ANGLE_WIDTH-1:0] sink_mag;
    logic                          source_sop;
    logic                          source_eop;
    logic                          source_valid;
    logic signed [DATA_WIDTH-1:0]  source_re;
    logic signed [DATA_WIDTH-1:0]  source_im;

    modport slave (
        input  sink_valid, sink_freq, sink_phase, sink_mag,
        output sink_ready, source_sop, source_eop, source_valid, source_re, source_im
    );

    modport master (
        output sink_valid, sink_freq, sink_phase, sink_mag,
        input  sink_ready, source_sop, source_eop, source_valid, source_re, source_im
    );
endinterface

// File: rtl/tone_synth_cordic_rot.sv
// Pipelined rotation-mode CORDIC, one iteration per register stage. Only the
// valid/sop/eop tags are reset; the datapath is free-running.
module cordic_rot
    import tone_synth_pkg::*;
#(
    parameter int CORDIC_STAGES = 16,
    parameter int WIDTH         = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_i,
    input  logic                    sop_i,
    input  logic                    eop_i,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic [ANGLE_WIDTH-1:0]  z_i,
    output logic                    valid_o,
    output logic                    sop_o,
    output logic                    eop_o,
    output logic signed [WIDTH-1:0] x_o,
    output logic signed [WIDTH-1:0] y_o
);

    for (genvar gi = 0; gi < CORDIC_STAGES; gi++) begin : g_stage
        logic signed [WIDTH-1:0] x_in, y_in, x_q, y_q;
        logic [ANGLE_WIDTH-1:0]  z_in;
        logic                    v_in, s_in, e_in, v_q, s_q, e_q;
        logic                    neg_in;

        if (gi == 0) begin : g_head
            assign x_in = x_i;
            assign y_in = '0;
            assign z_in = z_i;
            assign v_in = valid_i;
            assign s_in = sop_i;
            assign e_in = eop_i;
        end else begin : g_link
            assign x_in = g_stage[gi-1].x_q;
            assign y_in = g_stage[gi-1].y_q;
            assign z_in = g_stage[gi-1].g_angle.z_q;
            assign v_in = g_stage[gi-1].v_q;
            assign s_in = g_stage[gi-1].s_q;
            assign e_in = g_stage[gi-1].e_q;
        end

        assign neg_in = $signed(z_in) < 0;

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= 1'b0;
                s_q <= 1'b0;
                e_q <= 1'b0;
            end else begin
                v_q <= v_in;
                s_q <= s_in;
                e_q <= e_in;
            end
            if (neg_in) begin
                x_q <= x_in + (y_in >>> gi);
                y_q <= y_in - (x_in >>> gi);
            end else begin
                x_q <= x_in - (y_in >>> gi);
                y_q <= y_in + (x_in >>> gi);
            end
        end

        // The final iteration only needs the direction, so no residual is kept after it.
        if (gi < CORDIC_STAGES - 1) begin : g_angle
            logic [ANGLE_WIDTH-1:0] z_q;
            always_ff @(posedge clk) begin
                z_q <= neg_in ? z_in + ATAN_TABLE[gi] : z_in - ATAN_TABLE[gi];
            end
        end
    end

    assign valid_o = g_stage[CORDIC_STAGES-1].v_q;
    assign sop_o   = g_stage[CORDIC_STAGES-1].s_q;
    assign eop_o   = g_stage[CORDIC_STAGES-1].e_q;
    assign x_o     = g_stage[CORDIC_STAGES-1].x_q;
    assign y_o     = g_stage[CORDIC_STAGES-1].y_q;

endmodule

// File: rtl/tone_synth.sv
// Turns one tone record (bin, phase, magnitude) into a BATCH_SIZE-sample complex
// packet: phase accumulator + quadrant fold -> CORDIC -> round/saturate.
module tone_synth
    import tone_synth_pkg::*;
#(
    parameter int BATCH_SIZE    = 2048,
    parameter int DATA_WIDTH    = 14,
    parameter int CORDIC_STAGES = 16
) (
    input  logic        clk,
    input  logic        reset,
    tone_synth_if.slave bus
);

    localparam int FFT_DEPTH = $clog2(BATCH_SIZE);
    localparam int IW        = DATA_WIDTH + 3;
    localparam int PW        = DATA_WIDTH - 1 + 15;
    localparam logic signed [ANGLE_WIDTH-1:0] MAG_MAX = ANGLE_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [IW:0] SAT_HI     = (IW+1)'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [IW:0] SAT_LO     = ~SAT_HI;
    localparam logic [IW:0]        ROUND_HALF = (IW+1)'(1 << (FRAC_BITS-1));

    state_e                 state_q, state_d;
    logic [FFT_DEPTH-1:0]   n_q, n_d;
    logic [ANGLE_WIDTH-1:0] acc_q, acc_d, step_q, step_d;
    logic signed [IW-1:0]   x0_q, x0_d;
    logic                   issue, last;

    logic [DATA_WIDTH-2:0]  mag_clamped;
    logic [PW-1:0]          mag_prod;
    logic signed [IW-1:0]   mag_scaled;

    assign mag_clamped = bus.sink_mag[ANGLE_WIDTH-1] ? '0 :
                         (bus.sink_mag > MAG_MAX)    ? '1 : bus.sink_mag[DATA_WIDTH-2:0];
    assign mag_prod    = PW'(mag_clamped) * PW'(CORDIC_INV_GAIN);
    assign mag_scaled  = $signed(IW'(mag_prod >> (15 - FRAC_BITS)));

    assign last           = (n_q == FFT_DEPTH'(BATCH_SIZE - 1));
    assign bus.sink_ready = (state_q == IDLE) && !reset;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        step_d  = step_q;
        x0_d    = x0_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sink_valid) begin
                    acc_d   = bus.sink_phase;
                    step_d  = bus.sink_freq << (ANGLE_WIDTH - FFT_DEPTH);
                    x0_d    = mag_scaled;
                    n_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                acc_d = acc_q + step_q;
                n_d   = n_q + 1'b1;
                if (last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (eop_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            x0_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            x0_q    <= x0_d;
        end
    end

    // Angles in quadrants 2/3 are rotated by half a turn with x0 negated,
    // keeping the CORDIC residual inside its +-90 degree convergence range.
    logic                   fold_v_q, fold_s_q, fold_e_q;
    logic signed [IW-1:0]   fold_x_q;
    logic [ANGLE_WIDTH-1:0] fold_z_q;
    logic                   flip;

    assign flip = acc_q[ANGLE_WIDTH-1] ^ acc_q[ANGLE_WIDTH-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            fold_v_q <= 1'b0;
            fold_s_q <= 1'b0;
            fold_e_q <= 1'b0;
        end else begin
            fold_v_q <= issue;
            fold_s_q <= issue && (n_q == '0);
            fold_e_q <= issue && last;
        end
        if (issue) begin
            fold_x_q <= flip ? -x0_q : x0_q;
            fold_z_q <= flip ? {~acc_q[ANGLE_WIDTH-1], acc_q[ANGLE_WIDTH-2:0]} : acc_q;
        end
    end

    logic                 c_v, c_s, c_e;
    logic signed [IW-1:0] c_x, c_y;

    cordic_rot #(
        .CORDIC_STAGES(CORDIC_STAGES),
        .WIDTH        (IW)
    ) u_cordic (
        .clk    (clk),
        .reset  (reset),
        .valid_i(fold_v_q),
        .sop_i  (fold_s_q),
        .eop_i  (fold_e_q),
        .x_i    (fold_x_q),
        .z_i    (fold_z_q),
        .valid_o(c_v),
        .sop_o  (c_s),
        .eop_o  (c_e),
        .x_o    (c_x),
        .y_o    (c_y)
    );

    function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [IW-1:0] v);
        logic signed [IW:0] r;
        r = $signed({v[IW-1], v} + ROUND_HALF);
        r = r >>> FRAC_BITS;
        if (r > SAT_HI) begin
            r = SAT_HI;
        end else if (r < SAT_LO) begin
            r = SAT_LO;
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    logic                         valid_q, sop_q, eop_q;
    logic signed [DATA_WIDTH-1:0] re_q, im_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            valid_q <= c_v;
            sop_q   <= c_v && c_s;
            eop_q   <= c_v && c_e;
            if (c_v) begin
                re_q <= round_sat(c_x);
                im_q <= round_sat(c_y);
            end
        end
    end

    assign bus.source_valid = valid_q;
    assign bus.source_sop   = sop_q;
    assign bus.source_eop   = eop_q;
    assign bus.source_re    = re_q;
    assign bus.source_im    = im_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth: each accepted record pushes its ideal packet into
// a scoreboard that the output monitor pops and compares sample by sample.
module tb_tone_synth;
    localparam int    BATCH      = 2048;
    localparam int    DW         = 14;
    localparam int    STAGES     = 16;
    localparam int    SHIFT      = 32 - $clog2(BATCH);
    // Sample n is visible after edge t0+STAGES+2+n, i.e. during cycle t0+STAGES+3+n.
    localparam int    FIRST_EDGE = STAGES + 2;
    localparam real   TWO_PI     = 6.283185307179586;

    logic clk = 1'b0;
    logic reset = 1'b1;

    tone_synth_if #(.DATA_WIDTH(DW)) bus();

    tone_synth #(
        .BATCH_SIZE   (BATCH),
        .DATA_WIDTH   (DW),
        .CORDIC_STAGES(STAGES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        bit sop;
        bit eop;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pkt_samples = 0;
    int   pkt_count = 0;
    int   accept_cyc = -1;
    int   eop_cyc = -1;
    logic signed [DW-1:0] hold_re = '0;
    logic signed [DW-1:0] hold_im = '0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0d required=%0d cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp);
        bit ok;
        checks++;
        ok = (obs - exp <= 2) && (exp - obs <= 2);
        assert (ok === 1'b1) else begin
            failures++;
            $error("FAIL %s got=%0d required=%0d+-2 cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_packet(input logic [31:0] f, input logic [31:0] p, input logic [31:0] m, input int t0);
        logic [31:0] step;
        logic [31:0] th;
        int          magc;
        real         ang;
        exp_t        e;
        step = f << SHIFT;
        magc = ($signed(m) < 0) ? 0 : ($signed(m) > 8191) ? 8191 : int'($signed(m));
        for (int n = 0; n < BATCH; n++) begin
            th    = p + step * 32'(n);
            ang   = real'(th) * TWO_PI / 4294967296.0;
            e.re  = int'(real'(magc) * $cos(ang));
            e.im  = int'(real'(magc) * $sin(ang));
            e.sop = (n == 0);
            e.eop = (n == BATCH - 1);
            e.cyc = t0 + FIRST_EDGE + n;
            sb.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            sb.delete();
            hold_re = '0;
            hold_im = '0;
        end else if (bus.sink_valid && bus.sink_ready) begin
            accept_cyc = cyc;
            push_packet(bus.sink_freq, bus.sink_phase, bus.sink_mag, cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.source_valid === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_sample got=valid required=no_sample cyc=%0d", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                pkt_samples = bus.source_sop ? 1 : pkt_samples + 1;
                chk("sample_cycle", cyc, e.cyc);
                chk("sop", bus.source_sop, e.sop);
                chk("eop", bus.source_eop, e.eop);
                chk_tol("re", int'(bus.source_re), e.re);
                chk_tol("im", int'(bus.source_im), e.im);
                if (e.eop) begin
                    eop_cyc = cyc;
                    pkt_count++;
                    chk("ready_low_at_eop", bus.sink_ready, 0);
                    $display("packet %0d complete at cycle %0d samples=%0d", pkt_count, cyc, pkt_samples);
                end
            end
            hold_re = bus.source_re;
            hold_im = bus.source_im;
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("missing_sample", bus.source_valid, 1);
        end else begin
            chk("hold_re", bus.source_re, hold_re);
            chk("hold_im", bus.source_im, hold_im);
        end
    end

    task automatic send(input logic [31:0] f, input logic [31:0] p, input logic [31:0] m);
        int t = 0;
        @(negedge clk);
        bus.sink_valid = 1'b1;
        bus.sink_freq  = f;
        bus.sink_phase = p;
        bus.sink_mag   = m;
        while (bus.sink_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("accept_within_budget", int'(t < 5000), 1);
        @(posedge clk);
        $display("record accepted freq=%0d phase=0x%08h mag=%0d", $signed(f), p, $signed(m));
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        bus.sink_valid = 1'b0;
        while (sb.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("packet_within_budget", int'(t < 4000), 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int t;
        bus.sink_valid = 1'b0;
        bus.sink_freq  = '0;
        bus.sink_phase = '0;
        bus.sink_mag   = '0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", bus.sink_ready, 0);
        chk("reset_valid", bus.source_valid, 0);
        chk("reset_sop", bus.source_sop, 0);
        chk("reset_eop", bus.source_eop, 0);
        chk("reset_re", bus.source_re, 0);
        chk("reset_im", bus.source_im, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.sink_ready, 1);

        // DC tone, then quarter-rate tone, then pure phase offsets.
        send(32'd0, 32'h0000_0000, 32'd1000);
        drain();
        send(32'd512, 32'h0000_0000, 32'd1000);
        drain();
        send(32'd0, 32'h4000_0000, 32'd1000);
        drain();
        send(32'd0, 32'h8000_0000, 32'd1000);
        drain();

        // Magnitude clamps: above full scale and negative.
        send(32'd0, 32'h0000_0000, 32'd100000);
        drain();
        send(32'd0, 32'h0000_0000, -32'sd5);
        drain();

        // Second record held on sink_valid while the first packet streams.
        send(32'd37, 32'h1234_5678, 32'd3000);
        send(-32'sd3, 32'hC000_0000, 32'd2500);
        @(negedge clk);
        chk("b2b_accept_after_eop", accept_cyc, eop_cyc + 2);
        drain();

        // Reset in the middle of a packet, then a clean packet afterwards.
        pkt_samples = 0;
        send(32'd100, 32'h0000_0000, 32'd2000);
        @(negedge clk);
        bus.sink_valid = 1'b0;
        t = 0;
        while (pkt_samples < 700 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("reached_sample_700", int'(t < 3000), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_valid", bus.source_valid, 0);
        chk("midreset_eop", bus.source_eop, 0);
        chk("midreset_ready", bus.sink_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", bus.sink_ready, 1);
        send(32'd5, 32'h2000_0000, 32'd1500);
        drain();

        chk("scoreboard_empty", sb.size(), 0);
        chk("packets_completed", pkt_count, 9);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
